usb_transmit: RTL and testbench

- Transmit path of the USB encryptor link: serialises bytes onto a differential D+/D- pair.
- Accepts one byte per load_enable pulse and shifts it out LSB first, one bit per bit-time.
- Applies NRZI encoding and bit stuffing, and generates EOP (SE0, SE0, J) on request.
- Feeds the downstream receiver inside usb_top, or serves as a standalone line driver.

---
 rtl/usb_tx_pkg.sv | 34 +++
 rtl/usb_tx_shift.sv | 58 +++++
 rtl/usb_transmit.sv | 216 +++++++++++++++++++++
 tb/tb_usb_transmit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB transmit path.
// Build option: define LOW_SPEED_EN to swap J/K line polarity for low-speed signalling.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        STUFF   = 3'd3,
        HOLD    = 3'd4,
        EOP_SE0 = 3'd5,
        EOP_J   = 3'd6
    } tx_state_t;

    // Line encodings are {d_plus, d_minus}.
`ifdef LOW_SPEED_EN
    localparam logic [1:0] LINE_J = 2'b01;
    localparam logic [1:0] LINE_K = 2'b10;
`else
    localparam logic [1:0] LINE_J = 2'b10;
    localparam logic [1:0] LINE_K = 2'b01;
`endif
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam int         EOP_SE0_BITS = 2;
    localparam int         BYTE_BITS    = 8;

    // Map the NRZI level (1 = J, 0 = K) onto the line pair.
    function automatic logic [1:0] line_of(input logic level_j);
        return level_j ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_tx_shift.sv
// usb_tx_shift: byte holding latch plus 8-bit LSB-first serializer.
// ready is high while the holding latch is free to accept a new byte.
module usb_tx_shift
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       latch_en,
    input  logic [7:0] data,
    input  logic       move_en,
    input  logic       shift_en,
    output logic       cur_bit,
    output logic       last_bit,
    output logic       ready
);

    logic [7:0] hold_r;
    logic [7:0] shift_r;
    logic [2:0] bit_idx_r;
    logic       ready_r;

    // Holding latch: captures the byte on accept, frees up once it moves to the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r  <= 8'h00;
            ready_r <= 1'b1;
        end else if (latch_en) begin
            hold_r  <= data;
            ready_r <= 1'b0;
        end else if (move_en) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= ready_r;
        end
    end

    // Serializer: load from the latch, then shift right one bit per consumed bit-time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
        end else if (move_en) begin
            shift_r   <= hold_r;
            bit_idx_r <= 3'd0;
        end else if (shift_en) begin
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
        end else begin
            shift_r   <= shift_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    assign cur_bit  = shift_r[0];
    assign last_bit = (bit_idx_r == 3'(BYTE_BITS - 1));
    assign ready    = ready_r;

endmodule

// File: rtl/usb_transmit.sv
// usb_transmit: USB transmit line driver with NRZI encoding, bit stuffing and EOP generation.
// Build option: LOW_SPEED_EN (see usb_tx_pkg) selects low-speed J/K polarity.
module usb_transmit
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_enable,
    input  logic [7:0] data,
    input  logic       eop,
    output logic       ready,
    output logic       busy,
    output logic       d_plus,
    output logic       d_minus
);

    localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             tick_s, restart_s;
    logic             level_r, level_s;
    logic [2:0]       stuff_cnt_r, stuff_cnt_s;
    logic             byte_done_r, byte_done_s;
    logic [1:0]       eop_cnt_r, eop_cnt_s;
    logic [1:0]       line_r, line_s;
    logic             eop_q_r, eop_pend_r, eop_pend_s, eop_acc_s, eop_seen_s;
    logic             ready_r, busy_r, idle_next_s;
    logic             latch_s, move_s, shift_s;
    logic             cur_bit_s, last_bit_s, buf_ready_s;

    usb_tx_shift u_shift (
        .clk      (clk),
        .rst      (rst),
        .latch_en (latch_s),
        .data     (data),
        .move_en  (move_s),
        .shift_en (shift_s),
        .cur_bit  (cur_bit_s),
        .last_bit (last_bit_s),
        .ready    (buf_ready_s)
    );

    assign tick_s = (cnt_r == CNT_MAX);

    // Bit-time counter: restarts when a byte or EOP is accepted so latency is whole bit-times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (restart_s || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Only a rising edge of eop counts, and never while an EOP is already on the line.
    always_comb begin
        eop_acc_s = 1'b0;
        if (eop && !eop_q_r && (state_r != EOP_SE0) && (state_r != EOP_J)) begin
            eop_acc_s = 1'b1;
        end else begin
            eop_acc_s = 1'b0;
        end
    end

    assign eop_seen_s = eop_pend_r | eop_acc_s;

    // Next-state, NRZI level, stuff counter and next line value.
    always_comb begin
        state_s     = state_r;
        level_s     = level_r;
        stuff_cnt_s = stuff_cnt_r;
        byte_done_s = byte_done_r;
        eop_cnt_s   = eop_cnt_r;
        line_s      = line_r;
        restart_s   = 1'b0;
        latch_s     = 1'b0;
        move_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            IDLE, HOLD: begin
                if (load_enable && buf_ready_s) begin
                    state_s   = LOAD;
                    latch_s   = 1'b1;
                    restart_s = 1'b1;
                end else if (eop_seen_s) begin
                    state_s   = EOP_SE0;
                    restart_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                if (tick_s) begin
                    state_s = SHIFT;
                    move_s  = 1'b1;
                end else begin
                    state_s = LOAD;
                end
            end
            SHIFT: begin
                if (tick_s) begin
                    shift_s     = 1'b1;
                    byte_done_s = last_bit_s;
                    if (cur_bit_s) begin
                        stuff_cnt_s = stuff_cnt_r + 3'd1;
                    end else begin
                        level_s     = ~level_r;
                        stuff_cnt_s = 3'd0;
                    end
                    line_s = line_of(level_s);
                    if (stuff_cnt_s == STUFF_LIMIT) begin
                        state_s = STUFF;
                    end else if (last_bit_s) begin
                        state_s = eop_seen_s ? EOP_SE0 : HOLD;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            STUFF: begin
                if (tick_s) begin
                    level_s     = ~level_r;
                    stuff_cnt_s = 3'd0;
                    line_s      = line_of(level_s);
                    if (!byte_done_r) begin
                        state_s = SHIFT;
                    end else if (eop_seen_s) begin
                        state_s = EOP_SE0;
                    end else begin
                        state_s = HOLD;
                    end
                end else begin
                    state_s = STUFF;
                end
            end
            EOP_SE0: begin
                if (tick_s) begin
                    line_s = LINE_SE0;
                    if (eop_cnt_r == 2'(EOP_SE0_BITS - 1)) begin
                        eop_cnt_s = 2'd0;
                        state_s   = EOP_J;
                    end else begin
                        eop_cnt_s = eop_cnt_r + 2'd1;
                        state_s   = EOP_SE0;
                    end
                end else begin
                    state_s = EOP_SE0;
                end
            end
            EOP_J: begin
                if (tick_s) begin
                    line_s      = LINE_J;
                    level_s     = 1'b1;
                    stuff_cnt_s = 3'd0;
                    state_s     = IDLE;
                end else begin
                    state_s = EOP_J;
                end
            end
            default: begin
                state_s     = IDLE;
                level_s     = 1'b1;
                stuff_cnt_s = 3'd0;
                eop_cnt_s   = 2'd0;
                line_s      = LINE_J;
            end
        endcase
        // A pending EOP is consumed the moment the SE0 phase is entered.
        if ((state_s == EOP_SE0) && (state_r != EOP_SE0)) begin
            eop_pend_s = 1'b0;
        end else begin
            eop_pend_s = eop_seen_s;
        end
        idle_next_s = (state_s == IDLE) || (state_s == HOLD);
    end

    // State, encoder and registered line/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            level_r     <= 1'b1;
            stuff_cnt_r <= 3'd0;
            byte_done_r <= 1'b0;
            eop_cnt_r   <= 2'd0;
            line_r      <= LINE_J;
            eop_q_r     <= 1'b0;
            eop_pend_r  <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            level_r     <= level_s;
            stuff_cnt_r <= stuff_cnt_s;
            byte_done_r <= byte_done_s;
            eop_cnt_r   <= eop_cnt_s;
            line_r      <= line_s;
            eop_q_r     <= eop;
            eop_pend_r  <= eop_pend_s;
            ready_r     <= idle_next_s;
            busy_r      <= ~idle_next_s;
        end
    end

    assign d_plus  = line_r[1];
    assign d_minus = line_r[0];
    assign ready   = ready_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_usb_transmit.sv
// tb_usb_transmit: scoreboard bench for usb_transmit (CLKS_PER_BIT=1 and 8 instances).
module tb_usb_transmit;

`ifdef LOW_SPEED_EN
    localparam logic [1:0] J = 2'b01;
    localparam logic [1:0] K = 2'b10;
`else
    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
`endif
    localparam logic [1:0] SE0 = 2'b00;

    logic       tb_clk = 1'b0;
    logic       tb_n_rst = 1'b0;
    logic       load_enable = 1'b0;
    logic [7:0] data = 8'h00;
    logic       eop = 1'b0;
    logic       ready, busy, d_plus, d_minus;
    logic       load_enable8 = 1'b0;
    logic [7:0] data8 = 8'h00;
    logic       eop8 = 1'b0;
    logic       ready8, busy8, d_plus8, d_minus8;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];
    logic       model_lvl = 1'b1;
    int         model_cnt = 0;

    always #5 tb_clk = ~tb_clk;

    usb_transmit #(.CLKS_PER_BIT(1)) u_dut (
        .clk(tb_clk), .rst(~tb_n_rst), .load_enable(load_enable), .data(data), .eop(eop),
        .ready(ready), .busy(busy), .d_plus(d_plus), .d_minus(d_minus)
    );

    usb_transmit #(.CLKS_PER_BIT(8)) u_dut8 (
        .clk(tb_clk), .rst(~tb_n_rst), .load_enable(load_enable8), .data(data8), .eop(eop8),
        .ready(ready8), .busy(busy8), .d_plus(d_plus8), .d_minus(d_minus8)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [1:0] lvl_code(input logic l);
        return l ? J : K;
    endfunction

    // Reference encoder: NRZI plus stuffing, one queue entry per bit-time.
    task automatic model_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                model_cnt++;
            end else begin
                model_lvl = ~model_lvl;
                model_cnt = 0;
            end
            exp_q.push_back(lvl_code(model_lvl));
            if (model_cnt == 6) begin
                model_lvl = ~model_lvl;
                model_cnt = 0;
                exp_q.push_back(lvl_code(model_lvl));
            end
        end
    endtask

    task automatic model_eop();
        exp_q.push_back(SE0);
        exp_q.push_back(SE0);
        exp_q.push_back(J);
        model_lvl = 1'b1;
        model_cnt = 0;
    endtask

    // Pop one expected line value per bit-time; optionally pulse a load while busy.
    task automatic drain(input string tag, input int inject_at);
        int n;
        logic [1:0] want;
        n = 0;
        while (exp_q.size() > 0) begin
            @(posedge tb_clk); #1;
            load_enable = 1'b0;
            if (n == 1) eop = 1'b0;
            want = exp_q.pop_front();
            check({tag, "_line"}, 8'({d_plus, d_minus}), 8'(want));
            if (exp_q.size() > 0) check({tag, "_busy"}, 8'(busy), 8'd1);
            if (n == inject_at) begin
                load_enable = 1'b1;
                data = 8'hAA;
            end
            n++;
        end
        load_enable = 1'b0;
        check({tag, "_ready_after"}, 8'(ready), 8'd1);
        check({tag, "_busy_after"}, 8'(busy), 8'd0);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic with_eop,
                             input int inject_at);
        logic [1:0] prev;
        check({tag, "_ready_before"}, 8'(ready), 8'd1);
        prev = {d_plus, d_minus};
        load_enable = 1'b1;
        data = b;
        eop = with_eop;
        model_byte(b);
        if (with_eop) model_eop();
        @(posedge tb_clk); #1;
        load_enable = 1'b0;
        eop = 1'b0;
        check({tag, "_accept_line"}, 8'({d_plus, d_minus}), 8'(prev));
        check({tag, "_accept_busy"}, 8'(busy), 8'd1);
        @(posedge tb_clk); #1;
        check({tag, "_load_line"}, 8'({d_plus, d_minus}), 8'(prev));
        drain(tag, inject_at);
    endtask

    initial begin
        logic [1:0] seq8[$];
        logic [1:0] want;
        int idx;

        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_line", 8'({d_plus, d_minus}), 8'(J));
        check("rst_ready", 8'(ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        @(negedge tb_clk);
        tb_n_rst = 1'b1;
        @(posedge tb_clk); #1;

        // Sync byte, then a run of ones that forces stuffing across byte boundaries.
        send_byte("sync", 8'h80, 1'b0, -1);
        send_byte("ff1", 8'hFF, 1'b0, 3);
        send_byte("ff2", 8'hFF, 1'b0, -1);
        send_byte("eop3c", 8'h3C, 1'b1, -1);

        // Idle after EOP stays J.
        for (int i = 0; i < 3; i++) begin
            @(posedge tb_clk); #1;
            check("post_eop_idle", 8'({d_plus, d_minus}), 8'(J));
        end

        // New packet from J with a clean stuff count, then a held eop from HOLD.
        send_byte("pkt2", 8'h80, 1'b0, -1);
        eop = 1'b1;
        model_eop();
        @(posedge tb_clk); #1;
        check("eop_hold_accept", 8'({d_plus, d_minus}), 8'(K));
        drain("eop_hold", -1);
        for (int i = 0; i < 4; i++) begin
            @(posedge tb_clk); #1;
            check("single_eop_line", 8'({d_plus, d_minus}), 8'(J));
            check("single_eop_busy", 8'(busy), 8'd0);
        end

        // Reset in the middle of a byte.
        load_enable = 1'b1;
        data = 8'h55;
        @(posedge tb_clk); #1;
        load_enable = 1'b0;
        repeat (4) @(posedge tb_clk);
        #2;
        check("mid_busy", 8'(busy), 8'd1);
        tb_n_rst = 1'b0;
        #1;
        check("mid_rst_line", 8'({d_plus, d_minus}), 8'(J));
        check("mid_rst_ready", 8'(ready), 8'd1);
        check("mid_rst_busy", 8'(busy), 8'd0);
        @(negedge tb_clk);
        tb_n_rst = 1'b1;
        model_lvl = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge tb_clk); #1;
            check("after_rst_line", 8'({d_plus, d_minus}), 8'(J));
        end

        // Slow instance: 0x80 plus EOP, every level held a whole number of 8-cycle bit-times.
        model_byte(8'h80);
        model_eop();
        while (exp_q.size() > 0) seq8.push_back(exp_q.pop_front());
        check("slow_ready_before", 8'(ready8), 8'd1);
        load_enable8 = 1'b1;
        data8 = 8'h80;
        eop8 = 1'b1;
        @(posedge tb_clk); #1;
        load_enable8 = 1'b0;
        eop8 = 1'b0;
        for (int k = 1; k <= 112; k++) begin
            @(posedge tb_clk); #1;
            idx = (k < 16) ? -1 : (k - 16) / 8;
            if (idx < 0 || idx >= seq8.size()) want = J;
            else want = seq8[idx];
            check("slow_line", 8'({d_plus8, d_minus8}), 8'(want));
        end
        check("slow_ready_after", 8'(ready8), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
